// File: rtl/load_store_unit.sv
// load_store_unit: sequences load/store requests onto a synchronous 32x32 data memory port
// and returns a buffered response over a valid/ready handshake.
// Build option: define LSU_BYTE_ADDR_EN to treat the effective address as a byte address
// (word aligned, mem_addr = EA[AW+1:2]); undefined, EA is a word address.
module load_store_unit #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 32,
    parameter int OFFW  = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wr,
    input  logic [DW-1:0]   req_base,
    input  logic [OFFW-1:0] req_off,
    input  logic [DW-1:0]   req_wdata,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_datain,
    output logic            mem_sigwr,
    output logic            mem_sigon,
    input  logic [DW-1:0]   mem_dataout,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic            rsp_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
    state_t          state;
    logic            wr;
    logic [DW-1:0]   wdata;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   ea;
    logic            ea_err;
    logic [AW-1:0]   ea_addr;
    // effective address, wrapping modulo 2^DW, plus range (and alignment) check
    always_comb begin
        ea = req_base + {{(DW-OFFW){req_off[OFFW-1]}}, req_off};
`ifdef LSU_BYTE_ADDR_EN
        ea_err  = (ea[1:0] != 2'b00) || ((ea >> 2) >= DW'(DEPTH));
        ea_addr = ea[AW+1:2];
`else
        ea_err  = ea >= DW'(DEPTH);
        ea_addr = ea[AW-1:0];
`endif
    end
    // memory port is only driven during ISSUE, so an async reset drops it immediately
    always_comb begin
        req_ready  = state == IDLE;
        mem_sigon  = state == ISSUE;
        mem_sigwr  = (state == ISSUE) ? wr : 1'b0;
        mem_addr   = (state == ISSUE) ? addr : '0;
        mem_datain = (state == ISSUE) ? wdata : '0;
    end
    // request sequencing and registered response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr        <= 1'b0;
            wdata     <= '0;
            addr      <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr    <= req_wr;
                        wdata <= req_wdata;
                        if (ea_err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                            state     <= RESP;
                        end else begin
                            addr  <= ea_addr;
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= CAPTURE;
                CAPTURE: begin
                    rsp_rdata <= wr ? wdata : mem_dataout;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit against a memory reference model.
module tb_load_store_unit;
`ifdef LSU_BYTE_ADDR_EN
    localparam int SH = 2;
`else
    localparam int SH = 0;
`endif
    logic        clk = 0;
    logic        rst_n = 0;
    logic        req_valid = 0;
    logic        req_ready;
    logic        req_wr = 0;
    logic [31:0] req_base = 0;
    logic [15:0] req_off = 0;
    logic [31:0] req_wdata = 0;
    logic [4:0]  mem_addr;
    logic [31:0] mem_datain;
    logic        mem_sigwr;
    logic        mem_sigon;
    logic [31:0] mem_dataout = 0;
    logic        rsp_valid;
    logic        rsp_ready = 0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem [32] = '{default: 32'h0};
    logic [31:0] ref_mem [32] = '{default: 32'h0};
    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_base(req_base), .req_off(req_off), .req_wdata(req_wdata),
        .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_sigwr(mem_sigwr),
        .mem_sigon(mem_sigon), .mem_dataout(mem_dataout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    // synchronous memory: read data valid the cycle after the access edge
    always @(posedge clk) begin
        if (mem_sigon) begin
            if (mem_sigwr) mem[mem_addr] <= mem_datain;
            mem_dataout <= mem_sigwr ? mem_datain : mem[mem_addr];
        end
    end

    function automatic logic [31:0] ea_of(input logic [31:0] b, input logic [15:0] o);
        return 32'(longint'(b) + longint'($signed(o)));
    endfunction

    function automatic logic err_of(input logic [31:0] e);
        if (SH == 2) return (e % 4 != 0) || (e / 4 >= 32);
        return e >= 32;
    endfunction

    function automatic int idx_of(input logic [31:0] e);
        return int'(e >> SH);
    endfunction

    // one request/response with immediate handshake; reports what the memory port showed
    task automatic xact(input logic wr, input logic [31:0] base, input logic [15:0] off,
                        input logic [31:0] wd, output logic [31:0] rd, output logic er,
                        output int lat, output int ons, output logic [4:0] a_seen,
                        output logic w_seen, output int bad);
        @(negedge clk);
        req_valid = 1; req_wr = wr; req_base = base; req_off = off; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 0;
        lat = 1; ons = 0; bad = 0; a_seen = 0; w_seen = 0;
        while (!rsp_valid && lat < 10) begin
            if (mem_sigon) begin
                ons++; a_seen = mem_addr; w_seen = mem_sigwr;
            end else if (mem_addr != 0 || mem_datain != 0 || mem_sigwr) bad++;
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata; er = rsp_err;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #1;
        total_cnt++;
        if ({mem_addr, mem_datain, mem_sigwr, mem_sigon, rsp_valid, rsp_rdata, rsp_err} !== '0)
            $display("FAIL reset_outputs: got addr=%0d din=%h wr=%b on=%b v=%b rd=%h err=%b want all 0",
                     mem_addr, mem_datain, mem_sigwr, mem_sigon, rsp_valid, rsp_rdata, rsp_err);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", req_ready);
        else pass_cnt++;
    endtask

`ifndef LSU_BYTE_ADDR_EN
    task automatic test_store_load();
        logic [31:0] rd; logic er, w; logic [4:0] a; int lat, ons, bad;
        xact(1, 32'd3, 16'd2, 32'hDEADBEEF, rd, er, lat, ons, a, w, bad);
        ref_mem[5] = 32'hDEADBEEF;
        total_cnt++; if (a !== 5'd5) $display("FAIL st_addr: got %0d want 5", a); else pass_cnt++;
        total_cnt++; if (w !== 1'b1) $display("FAIL st_sigwr: got %b want 1", w); else pass_cnt++;
        total_cnt++; if (ons !== 1) $display("FAIL st_sigon: got %0d cycles want 1", ons); else pass_cnt++;
        total_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL st_rdata: got %h want deadbeef", rd); else pass_cnt++;
        total_cnt++; if (er !== 1'b0) $display("FAIL st_err: got %b want 0", er); else pass_cnt++;
        total_cnt++; if (lat !== 3) $display("FAIL st_latency: got %0d want 3", lat); else pass_cnt++;
        total_cnt++; if (bad !== 0) $display("FAIL st_idle_port: got %0d nonzero cycles want 0", bad); else pass_cnt++;
        xact(0, 32'd5, 16'd0, 32'h0, rd, er, lat, ons, a, w, bad);
        total_cnt++; if (rd !== 32'hDEADBEEF) $display("FAIL ld_rdata: got %h want deadbeef", rd); else pass_cnt++;
        total_cnt++; if (w !== 1'b0) $display("FAIL ld_sigwr: got %b want 0", w); else pass_cnt++;
    endtask

    task automatic test_range();
        logic [31:0] rd; logic er, w; logic [4:0] a; int lat, ons, bad;
        xact(0, 32'd30, 16'd2, 32'h0, rd, er, lat, ons, a, w, bad);
        total_cnt++; if (er !== 1'b1) $display("FAIL rng_err: got %b want 1", er); else pass_cnt++;
        total_cnt++; if (rd !== 32'h0) $display("FAIL rng_rdata: got %h want 0", rd); else pass_cnt++;
        total_cnt++; if (ons !== 0) $display("FAIL rng_sigon: got %0d want 0", ons); else pass_cnt++;
        total_cnt++; if (lat !== 1) $display("FAIL rng_latency: got %0d want 1", lat); else pass_cnt++;
        xact(0, 32'd0, 16'hFFFF, 32'h0, rd, er, lat, ons, a, w, bad);
        total_cnt++; if (er !== 1'b1) $display("FAIL neg_err: got %b want 1", er); else pass_cnt++;
        total_cnt++; if (ons !== 0) $display("FAIL neg_sigon: got %0d want 0", ons); else pass_cnt++;
        xact(0, 32'hFFFFFFFF, 16'd2, 32'h0, rd, er, lat, ons, a, w, bad);
        total_cnt++; if (er !== 1'b0 || a !== 5'd1) $display("FAIL wrap: got err=%b addr=%0d want err=0 addr=1", er, a); else pass_cnt++;
    endtask
`else
    task automatic test_byte_addr();
        logic [31:0] rd; logic er, w; logic [4:0] a; int lat, ons, bad;
        xact(0, 32'h14, 16'd0, 32'h0, rd, er, lat, ons, a, w, bad);
        total_cnt++; if (a !== 5'd5 || ons !== 1) $display("FAIL byte_addr: got addr=%0d sigon=%0d want addr=5 sigon=1", a, ons); else pass_cnt++;
        total_cnt++; if (er !== 1'b0) $display("FAIL byte_err: got %b want 0", er); else pass_cnt++;
        xact(0, 32'h15, 16'd0, 32'h0, rd, er, lat, ons, a, w, bad);
        total_cnt++; if (er !== 1'b1) $display("FAIL misalign_err: got %b want 1", er); else pass_cnt++;
        total_cnt++; if (ons !== 0) $display("FAIL misalign_sigon: got %0d want 0", ons); else pass_cnt++;
        xact(0, 32'h80, 16'd0, 32'h0, rd, er, lat, ons, a, w, bad);
        total_cnt++; if (er !== 1'b1) $display("FAIL byte_range: got %b want 1", er); else pass_cnt++;
    endtask
`endif

    task automatic test_backpressure();
        int n;
        logic [31:0] exp;
        @(negedge clk);
        req_valid = 1; req_wr = 0; req_base = 32'(5 << SH); req_off = 0;
        @(posedge clk); #1;
        req_base = 32'(6 << SH);
        n = 0;
        while (!rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
        exp = ref_mem[5];
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total_cnt++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== exp || req_ready !== 1'b0)
                $display("FAIL bp_hold: cycle %0d got v=%b rd=%h rdy=%b want v=1 rd=%h rdy=0",
                         i, rsp_valid, rsp_rdata, req_ready, exp);
            else pass_cnt++;
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        total_cnt++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0)
            $display("FAIL bp_release: got rdy=%b v=%b want rdy=1 v=0", req_ready, rsp_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        req_valid = 0;
        total_cnt++;
        if (req_ready !== 1'b0) $display("FAIL bp_next_accept: got rdy=%b want 0", req_ready);
        else pass_cnt++;
        n = 0;
        while (!rsp_valid && n < 10) begin @(posedge clk); #1; n++; end
        total_cnt++;
        if (rsp_rdata !== ref_mem[6] || rsp_valid !== 1'b1)
            $display("FAIL bp_second: got v=%b rd=%h want v=1 rd=%h", rsp_valid, rsp_rdata, ref_mem[6]);
        else pass_cnt++;
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
    endtask

    task automatic test_reset_mid_store();
        logic [31:0] rd; logic er, w; logic [4:0] a; int lat, ons, bad;
        @(negedge clk);
        req_valid = 1; req_wr = 1; req_base = 32'(7 << SH); req_off = 0; req_wdata = 32'h1;
        @(posedge clk); #1;
        req_valid = 0;
        total_cnt++; if (mem_sigon !== 1'b1) $display("FAIL mid_issue: got sigon=%b want 1", mem_sigon); else pass_cnt++;
        rst_n = 0;
        #1;
        total_cnt++;
        if (mem_sigon !== 1'b0 || mem_sigwr !== 1'b0)
            $display("FAIL mid_drop: got sigon=%b sigwr=%b want 0 0", mem_sigon, mem_sigwr);
        else pass_cnt++;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        #1;
        total_cnt++; if (rsp_valid !== 1'b0) $display("FAIL mid_rsp: got v=%b want 0", rsp_valid); else pass_cnt++;
        xact(0, 32'(7 << SH), 16'd0, 32'h0, rd, er, lat, ons, a, w, bad);
        total_cnt++; if (rd !== ref_mem[7]) $display("FAIL mid_load: got %h want %h", rd, ref_mem[7]); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] rd, base, wd, e; logic [15:0] off; logic er, w, wr, xe; logic [4:0] a;
        int lat, ons, bad, idx;
        for (int k = 0; k < 40; k++) begin
            wr = 1'($urandom_range(0, 1));
            wd = $urandom();
            if ($urandom_range(0, 9) < 7) begin
                base = 32'($urandom_range(0, 34 << SH));
                off = 16'(int'($urandom_range(0, 8)) - 4);
            end else begin
                base = $urandom();
                off = 16'($urandom());
            end
            e = ea_of(base, off);
            xe = err_of(e);
            idx = xe ? 0 : idx_of(e);
            xact(wr, base, off, wd, rd, er, lat, ons, a, w, bad);
            total_cnt++;
            if (er !== xe || lat !== (xe ? 1 : 3) || ons !== (xe ? 0 : 1) || bad !== 0)
                $display("FAIL rnd_ctrl[%0d]: got err=%b lat=%0d on=%0d bad=%0d want err=%b lat=%0d on=%0d bad=0",
                         k, er, lat, ons, bad, xe, xe ? 1 : 3, xe ? 0 : 1);
            else pass_cnt++;
            if (xe) begin
                total_cnt++;
                if (rd !== 32'h0) $display("FAIL rnd_errdata[%0d]: got %h want 0", k, rd); else pass_cnt++;
            end else begin
                if (wr) ref_mem[idx] = wd;
                total_cnt++;
                if (rd !== ref_mem[idx] || a !== 5'(idx) || w !== wr)
                    $display("FAIL rnd_data[%0d]: got rd=%h addr=%0d wr=%b want rd=%h addr=%0d wr=%b",
                             k, rd, a, w, ref_mem[idx], idx, wr);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int resp;
        resp = 0;
        @(negedge clk);
        req_valid = 1; req_wr = 0; req_base = 32'(1 << SH); req_off = 0;
        rsp_ready = 1;
        for (int i = 0; i < 12; i++) begin
            if (req_ready) acc.push_back(i);
            if (rsp_valid) begin
                resp++;
                total_cnt++;
                if (rsp_rdata !== ref_mem[1] || rsp_err !== 1'b0)
                    $display("FAIL b2b_data: got rd=%h err=%b want rd=%h err=0", rsp_rdata, rsp_err, ref_mem[1]);
                else pass_cnt++;
            end
            @(negedge clk);
        end
        req_valid = 0;
        rsp_ready = 0;
        total_cnt++;
        if (acc.size() !== 3 || resp !== 3)
            $display("FAIL b2b_count: got accepts=%0d resps=%0d want 3 3", acc.size(), resp);
        else pass_cnt++;
        if (acc.size() >= 2) begin
            total_cnt++;
            if (acc[1] - acc[0] !== 4) $display("FAIL b2b_period: got %0d want 4", acc[1] - acc[0]);
            else pass_cnt++;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
`ifndef LSU_BYTE_ADDR_EN
        test_store_load();
        test_range();
`else
        test_byte_addr();
`endif
        test_reset_mid_store();
        test_backpressure();
        test_random();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
